// File: rtl/blur_chk_pkg.sv
// Shared types and constants for the blur/DoG scan checker and the blocks that
// share its image geometry.
package blur_chk_pkg;

    localparam int DEF_ROWS  = 480;
    localparam int DEF_COLS  = 640;
    localparam int DEF_PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scanState_e;

    // Bit offset of channel ch inside a packed multi-channel pixel word.
    function automatic int pixLsb(input int ch, input int pixW);
        return ch * pixW;
    endfunction

endpackage

// File: rtl/blur_scan_checker_pix_tol_cmp.sv
// Single-channel pixel comparator: flags |a - b| > tol when enabled.
module pix_tol_cmp #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] tol_i,
    input  logic             en_i,
    output logic             mismatch_o
);

    logic signed [PIX_W:0] diff;
    logic        [PIX_W:0] mag;

    // One extra bit keeps the full 0..2^PIX_W-1 magnitude, so 0 vs 255 gives 255.
    always_comb begin
        diff       = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
        mag        = diff[PIX_W] ? $unsigned(-diff) : $unsigned(diff);
        mismatch_o = en_i && (mag > {1'b0, tol_i});
    end

endmodule

// File: rtl/blur_scan_checker.sv
// Raster scan-and-compare engine: reads all channels of an image memory, checks
// them against a golden pixel stream and reports/counts per-channel mismatches.
module blur_scan_checker
    import blur_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9,
    parameter int CNT_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [PIX_W-1:0]        tolerance,
    output logic                    rd_en,
    output logic [ROW_W-1:0]        rd_row,
    output logic [COL_W-1:0]        rd_col,
    input  logic [NUM_CH*PIX_W-1:0] rd_data,
    input  logic                    gold_valid,
    output logic                    gold_ready,
    input  logic [NUM_CH*PIX_W-1:0] gold_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_valid,
    output logic [NUM_CH-1:0]       err_mask,
    output logic [ROW_W-1:0]        err_row,
    output logic [COL_W-1:0]        err_col,
    output logic [NUM_CH*CNT_W-1:0] err_count,
    output logic                    any_error
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    scanState_e state_q, state_d;

    logic [NUM_CH-1:0]                  mask_q, mask_d;
    logic [PIX_W-1:0]                   tol_q, tol_d;
    logic [ROW_W-1:0]                   row_q, row_d;
    logic [COL_W-1:0]                   col_q, col_d;
    logic                               s1Valid_q, s1Valid_d;
    logic [NUM_CH*PIX_W-1:0]            s1Gold_q, s1Gold_d;
    logic [ROW_W-1:0]                   s1Row_q, s1Row_d;
    logic [COL_W-1:0]                   s1Col_q, s1Col_d;
    logic                               errValid_q, errValid_d;
    logic [NUM_CH-1:0]                  errMask_q, errMask_d;
    logic [ROW_W-1:0]                   errRow_q, errRow_d;
    logic [COL_W-1:0]                   errCol_q, errCol_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       errCount_q, errCount_d;
    logic                               anyError_q, anyError_d;

    logic              xfer;
    logic              lastPix;
    logic [NUM_CH-1:0] chMis;
    logic              anyMis;

    // Stage 1 compares the memory word returned for the previous read against
    // the golden word captured alongside that read.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
        pix_tol_cmp #(
            .PIX_W (PIX_W)
        ) u_cmp (
            .a_i        (rd_data[pixLsb(k, PIX_W) +: PIX_W]),
            .b_i        (s1Gold_q[pixLsb(k, PIX_W) +: PIX_W]),
            .tol_i      (tol_q),
            .en_i       (s1Valid_q && mask_q[k]),
            .mismatch_o (chMis[k])
        );
    end

    assign anyMis  = |chMis;
    assign lastPix = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign xfer    = gold_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (xfer && lastPix) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        gold_ready = 1'b0;
        unique case (state_q)
            SCAN: begin
                busy       = 1'b1;
                gold_ready = gold_valid;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign rd_en     = gold_ready;
    assign rd_row    = row_q;
    assign rd_col    = col_q;
    assign err_valid = errValid_q;
    assign err_mask  = errMask_q;
    assign err_row   = errRow_q;
    assign err_col   = errCol_q;
    assign err_count = errCount_q;
    assign any_error = anyError_q;

    always_comb begin
        mask_d     = mask_q;
        tol_d      = tol_q;
        row_d      = row_q;
        col_d      = col_q;
        s1Valid_d  = xfer;
        s1Gold_d   = s1Gold_q;
        s1Row_d    = s1Row_q;
        s1Col_d    = s1Col_q;
        errValid_d = 1'b0;
        errMask_d  = errMask_q;
        errRow_d   = errRow_q;
        errCol_d   = errCol_q;
        errCount_d = errCount_q;
        anyError_d = anyError_q;

        if (state_q == IDLE && start) begin
            mask_d     = ch_mask;
            tol_d      = tolerance;
            row_d      = '0;
            col_d      = '0;
            errCount_d = '0;
            anyError_d = 1'b0;
        end

        // The address returns to (0,0) after the final pixel so an idle engine
        // presents a clean read address.
        if (xfer) begin
            s1Gold_d = gold_data;
            s1Row_d  = row_q;
            s1Col_d  = col_q;
            if (lastPix) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == LAST_COL) begin
                row_d = row_q + 1'b1;
                col_d = '0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (anyMis) begin
            errValid_d = 1'b1;
            errMask_d  = chMis;
            errRow_d   = s1Row_q;
            errCol_d   = s1Col_q;
            anyError_d = 1'b1;
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (chMis[k] && (errCount_q[k] != '1)) begin
                errCount_d[k] = errCount_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            tol_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            s1Valid_q  <= 1'b0;
            s1Gold_q   <= '0;
            s1Row_q    <= '0;
            s1Col_q    <= '0;
            errValid_q <= 1'b0;
            errMask_q  <= '0;
            errRow_q   <= '0;
            errCol_q   <= '0;
            errCount_q <= '0;
            anyError_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            tol_q      <= tol_d;
            row_q      <= row_d;
            col_q      <= col_d;
            s1Valid_q  <= s1Valid_d;
            s1Gold_q   <= s1Gold_d;
            s1Row_q    <= s1Row_d;
            s1Col_q    <= s1Col_d;
            errValid_q <= errValid_d;
            errMask_q  <= errMask_d;
            errRow_q   <= errRow_d;
            errCol_q   <= errCol_d;
            errCount_q <= errCount_d;
            anyError_q <= anyError_d;
        end
    end

endmodule

// File: tb/tb_blur_scan_checker.sv
// Randomized self-checking bench for blur_scan_checker on a 4x4, 4-channel image
// with 3-bit error counters, checked against a pixel-list reference model.
module tb_blur_scan_checker;

    localparam int NC     = 4;
    localparam int PW     = 8;
    localparam int R      = 4;
    localparam int C      = 4;
    localparam int CW     = 2;
    localparam int RW     = 2;
    localparam int KW     = 3;
    localparam int NPIX   = R * C;
    localparam int SATMAX = (1 << KW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NC-1:0]     chMask = '0;
    logic [PW-1:0]     tolerance = '0;
    logic              rdEn;
    logic [RW-1:0]     rdRow;
    logic [CW-1:0]     rdCol;
    logic [NC*PW-1:0]  rdData = '0;
    logic              goldValid = 1'b0;
    logic              goldReady;
    logic [NC*PW-1:0]  goldData;
    logic              busy;
    logic              done;
    logic              errValid;
    logic [NC-1:0]     errMask;
    logic [RW-1:0]     errRow;
    logic [CW-1:0]     errCol;
    logic [NC*KW-1:0]  errCount;
    logic              anyError;

    logic [NC*PW-1:0]  memPix  [NPIX];
    logic [NC*PW-1:0]  goldPix [NPIX];
    int                gptr = 0;
    bit                gptrClr = 1'b0;

    int checks = 0;
    int errors = 0;

    int              expIdx[$];
    logic [NC-1:0]   expMask[$];
    int              expCnt[NC];
    int              obsIdx[$];
    logic [NC-1:0]   obsMask[$];
    int              obsRd, obsRdBad, obsAddrBad, obsGrBad, obsAfterBad;
    int              doneCycle, lastOfferCycle;
    logic [NC*KW-1:0] doneCount;
    logic            doneAny;

    blur_scan_checker #(
        .NUM_CH (NC), .PIX_W (PW), .COLS (C), .ROWS (R),
        .COL_W (CW), .ROW_W (RW), .CNT_W (KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_mask    (chMask),
        .tolerance  (tolerance),
        .rd_en      (rdEn),
        .rd_row     (rdRow),
        .rd_col     (rdCol),
        .rd_data    (rdData),
        .gold_valid (goldValid),
        .gold_ready (goldReady),
        .gold_data  (goldData),
        .busy       (busy),
        .done       (done),
        .err_valid  (errValid),
        .err_mask   (errMask),
        .err_row    (errRow),
        .err_col    (errCol),
        .err_count  (errCount),
        .any_error  (anyError)
    );

    always #5 clk = ~clk;

    // Golden stream source and one-cycle-latency image memory.
    assign goldData = (gptr < NPIX) ? goldPix[gptr] : '0;

    always @(posedge clk) begin
        if (gptrClr) gptr <= 0;
        else if (goldValid && goldReady) gptr <= gptr + 1;
        if (rdEn) rdData <= memPix[{rdRow, rdCol}];
    end

    function automatic int pixByte(input logic [NC*PW-1:0] w, input int k);
        return int'(w[k*PW +: PW]);
    endfunction

    function automatic int cntOf(input logic [NC*KW-1:0] v, input int k);
        return int'(v[k*KW +: KW]);
    endfunction

    // Reference: every pixel in raster order, mismatch when masked-in channel
    // differs by more than tolerance; counters clip at SATMAX.
    task automatic model_scan(input logic [NC-1:0] m, input int t);
        logic [NC-1:0] hit;
        int d;
        expIdx.delete();
        expMask.delete();
        for (int k = 0; k < NC; k++) expCnt[k] = 0;
        for (int p = 0; p < NPIX; p++) begin
            hit = '0;
            for (int k = 0; k < NC; k++) begin
                d = pixByte(memPix[p], k) - pixByte(goldPix[p], k);
                if (d < 0) d = -d;
                if (m[k] && d > t) hit[k] = 1'b1;
            end
            if (hit != '0) begin
                expIdx.push_back(p);
                expMask.push_back(hit);
                for (int k = 0; k < NC; k++)
                    if (hit[k] && expCnt[k] < SATMAX) expCnt[k]++;
            end
        end
    endtask

    task automatic fill_random_equal();
        for (int p = 0; p < NPIX; p++) begin
            memPix[p]  = $urandom;
            goldPix[p] = memPix[p];
        end
    endtask

    // Drives one scan (mode 0: gold always valid, 1: 1,0,0 pattern, 2: random)
    // and records what the DUT showed; comparisons are done by the callers.
    task automatic run_scan(input logic [NC-1:0] m, input logic [PW-1:0] t,
                            input int mode, input bit noise);
        int offered;
        obsIdx.delete();
        obsMask.delete();
        obsRd = 0; obsRdBad = 0; obsAddrBad = 0; obsGrBad = 0; obsAfterBad = 0;
        doneCycle = -1; lastOfferCycle = -1; offered = 0;
        doneCount = '0; doneAny = 1'b0;
        @(posedge clk); #1;
        gptrClr = 1'b1; start = 1'b0; goldValid = 1'b0;
        @(posedge clk); #1;
        gptrClr = 1'b0; start = 1'b1; chMask = m; tolerance = t; goldValid = 1'b1;
        #1;
        if (goldReady) obsGrBad++;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            chMask    = NC'($urandom);
            tolerance = PW'($urandom);
            case (mode)
                0:       goldValid = 1'b1;
                1:       goldValid = ((c - 1) % 3 == 0);
                default: goldValid = 1'($urandom_range(0, 1));
            endcase
            if (offered < NPIX && goldValid) begin
                offered++;
                if (offered == NPIX) lastOfferCycle = c;
            end
            #1;
            if (obsRd < NPIX) begin
                if (rdEn !== goldValid) obsRdBad++;
            end else if (goldReady) begin
                obsGrBad++;
            end
            if (rdEn) begin
                if (int'({rdRow, rdCol}) != obsRd) obsAddrBad++;
                obsRd++;
            end
            if (errValid) begin
                obsIdx.push_back(int'({errRow, errCol}));
                obsMask.push_back(errMask);
            end
            if (done) begin
                doneCycle = c;
                doneCount = errCount;
                doneAny   = anyError;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; goldValid = 1'b0;
        #1;
        if (done !== 1'b0 || busy !== 1'b0) obsAfterBad++;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; goldValid = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
        checks++; if (rdEn !== 1'b0 || goldReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: rd_en %0b gold_ready %0b want 0", rdEn, goldReady); end
        checks++; if (errValid !== 1'b0 || errMask !== '0 || errRow !== '0 || errCol !== '0) begin
            errors++; $display("[TB] FAIL reset_err: valid %0b mask %0h row %0d col %0d want 0", errValid, errMask, errRow, errCol); end
        checks++; if (errCount !== '0 || anyError !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt: count %0h any %0b want 0", errCount, anyError); end
        checks++; if (rdRow !== '0 || rdCol !== '0) begin errors++; $display("[TB] FAIL reset_addr: row %0d col %0d want 0", rdRow, rdCol); end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; goldValid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_with_reset: busy %0b want 0", busy); end
    endtask

    task automatic test_identical();
        fill_random_equal();
        model_scan(4'hF, 0);
        run_scan(4'hF, 8'd0, 0, 1'b0);
        checks++; if (obsIdx.size() != 0) begin errors++; $display("[TB] FAIL ident_errs: got %0d want 0", obsIdx.size()); end
        checks++; if (doneCycle != NPIX + 2) begin errors++; $display("[TB] FAIL ident_done_cycle: got %0d want %0d", doneCycle, NPIX + 2); end
        checks++; if (doneCount !== '0 || doneAny !== 1'b0) begin errors++; $display("[TB] FAIL ident_counts: got %0h any %0b want 0", doneCount, doneAny); end
        checks++; if (obsRd != NPIX || obsAddrBad != 0 || obsRdBad != 0) begin
            errors++; $display("[TB] FAIL ident_reads: reads %0d addr_bad %0d rd_bad %0d want %0d 0 0", obsRd, obsAddrBad, obsRdBad, NPIX); end
        checks++; if (obsGrBad != 0 || gptr != NPIX) begin errors++; $display("[TB] FAIL ident_gold_consume: bad %0d consumed %0d want 0 %0d", obsGrBad, gptr, NPIX); end
        checks++; if (obsAfterBad != 0) begin errors++; $display("[TB] FAIL ident_done_pulse: bad %0d want 0", obsAfterBad); end
    endtask

    task automatic test_single_error();
        fill_random_equal();
        memPix[7][23:16]  = 8'd200;
        goldPix[7][23:16] = 8'd197;
        model_scan(4'hF, 2);
        run_scan(4'hF, 8'd2, 0, 1'b0);
        checks++; if (obsIdx.size() != 1 || expIdx.size() != 1) begin
            errors++; $display("[TB] FAIL single_count: got %0d want 1", obsIdx.size()); end
        else begin
            checks++; if (obsMask[0] !== 4'b0100 || obsIdx[0] != 7) begin
                errors++; $display("[TB] FAIL single_event: mask %0b idx %0d want 0100 7", obsMask[0], obsIdx[0]); end
        end
        checks++; if (errRow !== 2'd1 || errCol !== 2'd3) begin errors++; $display("[TB] FAIL single_coord: row %0d col %0d want 1 3", errRow, errCol); end
        checks++; if (cntOf(doneCount, 2) != 1 || cntOf(doneCount, 0) != 0 || doneAny !== 1'b1) begin
            errors++; $display("[TB] FAIL single_counts: count %0h any %0b want ch2=1 any=1", doneCount, doneAny); end
        run_scan(4'hF, 8'd3, 0, 1'b0);
        checks++; if (obsIdx.size() != 0 || doneAny !== 1'b0 || doneCount !== '0) begin
            errors++; $display("[TB] FAIL tol3_clean: errs %0d any %0b count %0h want 0", obsIdx.size(), doneAny, doneCount); end
        checks++; if (errMask !== 4'b0100 || errRow !== 2'd1 || errCol !== 2'd3) begin
            errors++; $display("[TB] FAIL err_hold: mask %0b row %0d col %0d want 0100 1 3", errMask, errRow, errCol); end
    endtask

    task automatic test_mask();
        int bad;
        for (int p = 0; p < NPIX; p++) begin
            memPix[p]  = '0;
            goldPix[p] = '1;
        end
        model_scan(4'b0011, 254);
        run_scan(4'b0011, 8'd254, 0, 1'b0);
        bad = 0;
        foreach (obsMask[i]) if (obsMask[i] !== 4'b0011) bad++;
        checks++; if (obsIdx.size() != expIdx.size() || bad != 0) begin
            errors++; $display("[TB] FAIL mask_events: got %0d bad %0d want %0d 0", obsIdx.size(), bad, expIdx.size()); end
        for (int k = 0; k < NC; k++) begin
            checks++; if (cntOf(doneCount, k) != expCnt[k]) begin
                errors++; $display("[TB] FAIL mask_count_ch%0d: got %0d want %0d", k, cntOf(doneCount, k), expCnt[k]); end
        end
    endtask

    task automatic test_stall();
        fill_random_equal();
        for (int p = 0; p < NPIX; p++)
            if ($urandom_range(0, 1) == 1) goldPix[p][15:8] = 8'($urandom);
        model_scan(4'hF, 1);
        run_scan(4'hF, 8'd1, 1, 1'b0);
        checks++; if (obsRdBad != 0 || obsRd != NPIX) begin
            errors++; $display("[TB] FAIL stall_reads: rd_bad %0d reads %0d want 0 %0d", obsRdBad, obsRd, NPIX); end
        checks++; if (obsAddrBad != 0) begin errors++; $display("[TB] FAIL stall_addr: bad %0d want 0", obsAddrBad); end
        checks++; if (doneCycle != lastOfferCycle + 2) begin
            errors++; $display("[TB] FAIL stall_done_cycle: got %0d want %0d", doneCycle, lastOfferCycle + 2); end
        checks++; if (obsIdx.size() != expIdx.size()) begin
            errors++; $display("[TB] FAIL stall_events: got %0d want %0d", obsIdx.size(), expIdx.size()); end
        else foreach (expIdx[i]) begin
            checks++; if (obsIdx[i] != expIdx[i] || obsMask[i] !== expMask[i]) begin
                errors++; $display("[TB] FAIL stall_event%0d: idx %0d mask %0b want %0d %0b", i, obsIdx[i], obsMask[i], expIdx[i], expMask[i]); end
        end
    endtask

    task automatic test_saturate();
        fill_random_equal();
        for (int p = 0; p < NPIX; p++) goldPix[p] = memPix[p] ^ 32'h0000_0080;
        model_scan(4'b0001, 5);
        run_scan(4'b0001, 8'd5, 0, 1'b0);
        checks++; if (obsIdx.size() != NPIX) begin errors++; $display("[TB] FAIL sat_events: got %0d want %0d", obsIdx.size(), NPIX); end
        checks++; if (cntOf(doneCount, 0) != SATMAX || expCnt[0] != SATMAX) begin
            errors++; $display("[TB] FAIL sat_count: got %0d want %0d", cntOf(doneCount, 0), SATMAX); end
        checks++; if (doneCount[NC*KW-1:KW] !== '0) begin errors++; $display("[TB] FAIL sat_others: got %0h want 0", doneCount[NC*KW-1:KW]); end
    endtask

    task automatic test_reset_mid();
        int rdCnt;
        bit sawDone, sawBusy;
        fill_random_equal();
        for (int p = 0; p < NPIX; p++) goldPix[p] = memPix[p] ^ 32'h0000_8000;
        @(posedge clk); #1;
        gptrClr = 1'b1;
        @(posedge clk); #1;
        gptrClr = 1'b0; start = 1'b1; chMask = 4'hF; tolerance = 8'd0; goldValid = 1'b1;
        rdCnt = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (rdEn) rdCnt++;
            if (rdCnt == 6) break;
        end
        checks++; if (rdCnt != 6 || anyError !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_prefix: reads %0d any %0b want 6 1", rdCnt, anyError); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rdEn !== 1'b0 || errValid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_abort: busy %0b rd_en %0b err_valid %0b want 0", busy, rdEn, errValid); end
        checks++; if (errCount !== '0 || anyError !== 1'b0 || errMask !== '0) begin
            errors++; $display("[TB] FAIL mid_clear: count %0h any %0b mask %0b want 0", errCount, anyError, errMask); end
        sawDone = 1'b0; sawBusy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checks++; if (sawDone || sawBusy) begin errors++; $display("[TB] FAIL mid_no_done: done %0b busy %0b want 0", sawDone, sawBusy); end
        model_scan(4'hF, 0);
        run_scan(4'hF, 8'd0, 0, 1'b0);
        checks++; if (obsAddrBad != 0 || obsIdx.size() != NPIX || obsIdx[0] != 0) begin
            errors++; $display("[TB] FAIL mid_rescan: addr_bad %0d events %0d want 0 %0d", obsAddrBad, obsIdx.size(), NPIX); end
        checks++; if (cntOf(doneCount, 1) != expCnt[1] || doneCycle != NPIX + 2) begin
            errors++; $display("[TB] FAIL mid_rescan_count: ch1 %0d cycle %0d want %0d %0d", cntOf(doneCount, 1), doneCycle, expCnt[1], NPIX + 2); end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] m;
        int t, v;
        for (int it = 0; it < 4; it++) begin
            for (int p = 0; p < NPIX; p++) begin
                memPix[p] = $urandom;
                for (int k = 0; k < NC; k++) begin
                    v = pixByte(memPix[p], k) + $urandom_range(0, 8) - 4;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                    goldPix[p][k*PW +: PW] = PW'(v);
                end
            end
            m = NC'($urandom);
            t = $urandom_range(0, 4);
            model_scan(m, t);
            run_scan(m, PW'(t), 2, 1'b1);
            checks++; if (doneCycle < 0 || doneCycle != lastOfferCycle + 2 || obsAfterBad != 0) begin
                errors++; $display("[TB] FAIL b2b%0d_done: cycle %0d want %0d after_bad %0d", it, doneCycle, lastOfferCycle + 2, obsAfterBad); end
            checks++; if (obsIdx.size() != expIdx.size()) begin
                errors++; $display("[TB] FAIL b2b%0d_events: got %0d want %0d", it, obsIdx.size(), expIdx.size()); end
            else foreach (expIdx[i]) begin
                checks++; if (obsIdx[i] != expIdx[i] || obsMask[i] !== expMask[i]) begin
                    errors++; $display("[TB] FAIL b2b%0d_event%0d: idx %0d mask %0b want %0d %0b", it, i, obsIdx[i], obsMask[i], expIdx[i], expMask[i]); end
            end
            for (int k = 0; k < NC; k++) begin
                checks++; if (cntOf(doneCount, k) != expCnt[k]) begin
                    errors++; $display("[TB] FAIL b2b%0d_count_ch%0d: got %0d want %0d", it, k, cntOf(doneCount, k), expCnt[k]); end
            end
            checks++; if (doneAny !== (expIdx.size() != 0)) begin
                errors++; $display("[TB] FAIL b2b%0d_any: got %0b want %0b", it, doneAny, expIdx.size() != 0); end
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_single_error();
        test_mask();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
